// File: rtl/mux_seq_n_pkg.sv
// rtl/mux_seq_n_pkg.sv - shared state encoding and index-width helper for mux_seq_n
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_seq_n_if.sv
// rtl/mux_seq_n_if.sv - output beat stream of mux_seq_n (data, index, last, valid/ready)
interface mux_seq_n_if #(
  parameter int W    = 8,
  parameter int SELW = 2
);
  logic signed [W-1:0] out_data;
  logic [SELW-1:0]     out_idx;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output out_data, out_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N-way indexed selector; MUX_SEQ_OOR_ZERO_EN picks zero vs clamp for out-of-range idx
module mux_n_comb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic [N*W-1:0]      data,
  input  logic [SELW-1:0]     idx,
  output logic signed [W-1:0] y,
  output logic [SELW-1:0]     y_idx
);

  always_comb begin
`ifdef MUX_SEQ_OOR_ZERO_EN
    y     = '0;
    y_idx = idx;
`else
    y     = data[(N-1)*W +: W];
    y_idx = SELW'(N-1);
`endif
    for (int i = 0; i < N; i++) begin
      if (idx == SELW'(i)) begin
        y     = data[i*W +: W];
        y_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_seq_n.sv
// rtl/mux_seq_n.sv - N-channel signed selector, manual or scan mode, registered valid/ready output
module mux_seq_n
  import mux_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  ch_data,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            req,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  mux_seq_n_if.master     stream
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SINGLE = SINGLE;
  localparam logic [1:0] ST_SCAN   = SCAN;

  logic [1:0]          state;
  logic [SELW-1:0]     nidx;
  logic signed [W-1:0] mux_y;
  logic [SELW-1:0]     mux_idx;
  logic                accept;

  assign accept = stream.out_valid && stream.out_ready;

  // One selector serves both the start load and every scan advance.
  always_comb begin
    nidx = sel;
    if (state == ST_SCAN) begin
      nidx = stream.out_idx + SELW'(1);
    end else if (mode) begin
      nidx = '0;
    end
  end

  mux_n_comb #(
    .N    (N),
    .W    (W),
    .SELW (SELW)
  ) u_sel (
    .data  (ch_data),
    .idx   (nidx),
    .y     (mux_y),
    .y_idx (mux_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      stream.out_data  <= '0;
      stream.out_idx   <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else if (abort) begin
      state            <= ST_IDLE;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            stream.out_data  <= mux_y;
            stream.out_idx   <= mux_idx;
            stream.out_valid <= 1'b1;
            stream.out_last  <= !mode;
            busy             <= 1'b1;
            state            <= mode ? ST_SCAN : ST_SINGLE;
          end
        end
        ST_SINGLE: begin
          if (accept) begin
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            done             <= 1'b1;
            busy             <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            if (stream.out_idx == SELW'(N-1)) begin
              stream.out_valid <= 1'b0;
              stream.out_last  <= 1'b0;
              done             <= 1'b1;
              busy             <= 1'b0;
              state            <= ST_IDLE;
            end else begin
              stream.out_data <= mux_y;
              stream.out_idx  <= mux_idx;
              stream.out_last <= (nidx == SELW'(N-1));
            end
          end
        end
        default: begin
          stream.out_valid <= 1'b0;
          stream.out_last  <= 1'b0;
          busy             <= 1'b0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_seq_n.sv
// tb/tb_mux_seq_n.sv - table-driven check of mux_seq_n (N=4) plus stall and out-of-range (N=3) sequences
module tb_mux_seq_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [31:0] ch_data;
  logic [1:0] sel;
  logic       mode, req, abort;
  logic       busy, done;

  logic [23:0] ch3_data;
  logic [1:0]  sel3;
  logic        req3, abort3;
  logic        busy3, done3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_seq_n_if #(.W(8), .SELW(2)) bus ();
  mux_seq_n_if #(.W(8), .SELW(2)) bus3 ();

  mux_seq_n #(.N(4), .W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_data (ch_data),
    .sel     (sel),
    .mode    (mode),
    .req     (req),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .stream  (bus.master)
  );

  mux_seq_n #(.N(3), .W(8)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_data (ch3_data),
    .sel     (sel3),
    .mode    (1'b0),
    .req     (req3),
    .abort   (abort3),
    .busy    (busy3),
    .done    (done3),
    .stream  (bus3.master)
  );

  typedef struct {
    logic       rst_n;
    logic       req;
    logic       mode;
    logic [1:0] sel;
    logic       ready;
    logic       abort;
    logic       valid;
    int         data;
    int         idx;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int ix,
                         input int l, input int b, input int dn);
    chk({tag, ".valid"}, int'(bus.out_valid), v);
    chk({tag, ".data"},  int'(bus.out_data),  d);
    chk({tag, ".idx"},   int'(bus.out_idx),   ix);
    chk({tag, ".last"},  int'(bus.out_last),  l);
    chk({tag, ".busy"},  int'(busy),          b);
    chk({tag, ".done"},  int'(done),          dn);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ch3=-128, ch2=100, ch1=7, ch0=-5
    ch_data  = {8'h80, 8'd100, 8'd7, 8'hFB};
    ch3_data = {8'd30, 8'd20, 8'd10};
    rst_n = 1'b0; req = 0; mode = 0; sel = 0; abort = 0;
    req3 = 0; sel3 = 0; abort3 = 0;
    bus.out_ready = 0; bus3.out_ready = 0;

    tbl[0]  = '{0,0,0,0,0,0, 0,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0, 0,0,0,0,0,0};
    tbl[2]  = '{1,1,0,2,1,0, 1,100,2,1,1,0};
    tbl[3]  = '{1,0,0,0,1,0, 0,100,2,0,0,1};
    tbl[4]  = '{1,0,0,0,1,0, 0,100,2,0,0,0};
    tbl[5]  = '{1,1,1,0,1,0, 1,-5,0,0,1,0};
    tbl[6]  = '{1,0,0,0,1,0, 1,7,1,0,1,0};
    tbl[7]  = '{1,0,0,0,1,0, 1,100,2,0,1,0};
    tbl[8]  = '{1,0,0,0,1,0, 1,-128,3,1,1,0};
    tbl[9]  = '{1,0,0,0,1,0, 0,-128,3,0,0,1};
    tbl[10] = '{1,1,0,1,0,0, 1,7,1,1,1,0};
    tbl[11] = '{1,0,0,0,0,0, 1,7,1,1,1,0};
    tbl[12] = '{1,0,0,0,1,0, 0,7,1,0,0,1};
    tbl[13] = '{1,1,1,0,1,0, 1,-5,0,0,1,0};
    tbl[14] = '{1,1,0,3,1,0, 1,7,1,0,1,0};
    tbl[15] = '{1,0,0,0,1,0, 1,100,2,0,1,0};
    tbl[16] = '{1,1,0,0,1,1, 0,100,2,0,0,0};
    tbl[17] = '{1,0,0,0,1,0, 0,100,2,0,0,0};
    tbl[18] = '{1,1,1,0,1,0, 1,-5,0,0,1,0};
    tbl[19] = '{1,0,0,0,1,0, 1,7,1,0,1,0};
    tbl[20] = '{0,0,0,0,1,0, 0,0,0,0,0,0};
    tbl[21] = '{1,1,1,0,0,0, 1,-5,0,0,1,0};
    tbl[22] = '{1,0,0,0,0,1, 0,-5,0,0,0,0};

    for (int i = 0; i < 23; i++) begin
      rst_n = tbl[i].rst_n; req = tbl[i].req; mode = tbl[i].mode;
      sel = tbl[i].sel; bus.out_ready = tbl[i].ready; abort = tbl[i].abort;
      tick();
      chk_out($sformatf("row%0d", i), int'(tbl[i].valid), tbl[i].data, tbl[i].idx,
              int'(tbl[i].last), int'(tbl[i].busy), int'(tbl[i].done));
    end
    rst_n = 1; req = 0; abort = 0; bus.out_ready = 0;
    tick();

    // Backpressure on beat 1 with a channel change during the stall
    req = 1; mode = 1; bus.out_ready = 0;
    tick();
    chk_out("bp.beat0", 1, -5, 0, 0, 1, 0);
    req = 0; bus.out_ready = 1;
    tick();
    chk_out("bp.beat1", 1, 7, 1, 0, 1, 0);
    bus.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) ch_data[15:8] = 8'd9;
      tick();
      chk_out($sformatf("bp.stall%0d", k), 1, 7, 1, 0, 1, 0);
    end
    bus.out_ready = 1;
    tick();
    chk_out("bp.beat2", 1, 100, 2, 0, 1, 0);
    tick();
    chk_out("bp.beat3", 1, -128, 3, 1, 1, 0);
    tick();
    chk_out("bp.done", 0, -128, 3, 0, 0, 1);
    bus.out_ready = 0;
    tick();
    chk("bp.done_pulse", int'(done), 0);

    // Out-of-range select on the N=3 instance
    req3 = 1; sel3 = 2'd3; bus3.out_ready = 0;
    tick();
    req3 = 0;
`ifdef MUX_SEQ_OOR_ZERO_EN
    chk("oor.data", int'(bus3.out_data), 0);
    chk("oor.idx",  int'(bus3.out_idx),  3);
`else
    chk("oor.data", int'(bus3.out_data), 30);
    chk("oor.idx",  int'(bus3.out_idx),  2);
`endif
    chk("oor.last", int'(bus3.out_last), 1);
    abort3 = 1;
    tick();
    abort3 = 0;
    chk("oor.abort_valid", int'(bus3.out_valid), 0);
    req3 = 1; sel3 = 2'd1; bus3.out_ready = 1;
    tick();
    req3 = 0;
    chk("n3.data", int'(bus3.out_data), 20);
    chk("n3.idx",  int'(bus3.out_idx),  1);
    tick();
    chk("n3.done", int'(done3), 1);
    chk("n3.busy", int'(busy3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
